div_exec_unit: RTL and testbench

- Iterative radix-2 integer divider. Executes RV32M DIV/DIVU/REM/REMU for the MUL/DIV issue path.
- Accepts one op per issue handshake from the MUL/DIV reservation station, with operands read from the PRF in the same cycle.
- Computes one quotient bit per cycle.
- Holds the result and requests a CDB port; drives the CDB broadcast when granted.
- Blocks further issue (in_ready low) while busy.

---
 rtl/div_exec_unit_pkg.sv | 33 +++
 rtl/div_core_step.sv | 31 +++
 rtl/div_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_div_exec_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_exec_unit_pkg.sv
// rtl/div_exec_unit_pkg.sv - shared types and widths for the iterative divider
package div_exec_unit_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_IDX_W = 5;
    localparam int PREG_W    = 6;
    localparam int CNT_W     = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    preg;
        logic [ROB_IDX_W-1:0] rob_id;
        logic [XLEN-1:0]      value;
    } cdb_t;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/div_core_step.sv
// rtl/div_core_step.sv - one combinational restoring-division step
//
// Ports:
//   rem_in   partial remainder before the step
//   quo_in   dividend/quotient shift register before the step
//   divisor  unsigned divisor magnitude
//   rem_out  partial remainder after the step
//   quo_out  shift register after the step (new quotient bit in bit 0)
module div_core_step
    import div_exec_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0]   trial;
    logic [XLEN-1:0] shifted_lo;

    // The partial remainder is always below the divisor, so shifting in one
    // dividend bit needs XLEN+1 bits before the subtract.
    always_comb begin
        trial      = {rem_in, quo_in[XLEN-1]} - {1'b0, divisor};
        shifted_lo = {rem_in[XLEN-2:0], quo_in[XLEN-1]};
        rem_out    = trial[XLEN] ? shifted_lo : trial[XLEN-1:0];
        quo_out    = {quo_in[XLEN-2:0], ~trial[XLEN]};
    end

endmodule

// File: rtl/div_exec_unit.sv
// rtl/div_exec_unit.sv - radix-2 iterative RV32M DIV/DIVU/REM/REMU execution unit
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                kills any in-flight op; no accept in the flush cycle
//   in_valid / in_ready  issue handshake with the reservation station
//   in_op                00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_rs1_val           dividend
//   in_rs2_val           divisor
//   in_pd, in_rob_id     destination preg and ROB tag, echoed on the CDB
//   cdb_req / cdb_grant  CDB arbitration handshake
//   cdb_out              broadcast payload, valid = cdb_req && cdb_grant
//   busy                 state != IDLE
module div_exec_unit
    import div_exec_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [XLEN-1:0]      in_rs1_val,
    input  logic [XLEN-1:0]      in_rs2_val,
    input  logic [PREG_W-1:0]    in_pd,
    input  logic [ROB_IDX_W-1:0] in_rob_id,
    output logic                 cdb_req,
    input  logic                 cdb_grant,
    output cdb_t                 cdb_out,
    output logic                 busy
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t state_q, state_d;

    logic [CNT_W-1:0]     counter_q;
    logic [XLEN-1:0]      rem_q, quo_q, dsr_q, result_q;
    logic                 neg_quo_q, neg_rem_q, is_rem_q;
    logic [PREG_W-1:0]    pd_q;
    logic [ROB_IDX_W-1:0] rob_q;

    // Issue-side decode of the incoming operands.
    logic            accept;
    logic            op_signed, op_rem;
    logic            neg1, neg2;
    logic [XLEN-1:0] abs1, abs2;
    logic            div_zero, sgn_ovf, special;
    logic [XLEN-1:0] special_val;

    always_comb begin
        op_signed   = (in_op == OP_DIV) || (in_op == OP_REM);
        op_rem      = in_op[1];
        neg1        = op_signed && in_rs1_val[XLEN-1];
        neg2        = op_signed && in_rs2_val[XLEN-1];
        // twos_neg(INT_MIN) == INT_MIN, which read as unsigned is 2^(XLEN-1).
        abs1        = neg1 ? twos_neg(in_rs1_val) : in_rs1_val;
        abs2        = neg2 ? twos_neg(in_rs2_val) : in_rs2_val;
        div_zero    = (in_rs2_val == '0);
        sgn_ovf     = op_signed && (in_rs1_val == INT_MIN) && (in_rs2_val == '1);
        special     = div_zero || sgn_ovf;
        if (div_zero) begin
            special_val = op_rem ? in_rs1_val : '1;
        end else begin
            special_val = op_rem ? '0 : INT_MIN;
        end
    end

    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] final_val;

    div_core_step u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        if (is_rem_q) begin
            final_val = neg_rem_q ? twos_neg(step_rem) : step_rem;
        end else begin
            final_val = neg_quo_q ? twos_neg(step_quo) : step_quo;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) state_d = special ? DONE : CALC;
                end
                CALC: begin
                    if (counter_q == CNT_W'(1)) state_d = DONE;
                end
                DONE: begin
                    if (cdb_grant) begin
                        if (accept) state_d = special ? DONE : CALC;
                        else        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs; a granted DONE cycle frees the unit for a same-cycle issue.
    always_comb begin
        in_ready       = (state_q == IDLE) || ((state_q == DONE) && cdb_grant);
        cdb_req        = (state_q == DONE) && !flush;
        busy           = (state_q != IDLE);
        accept         = in_valid && in_ready && !flush;
        cdb_out.valid  = cdb_req && cdb_grant;
        cdb_out.preg   = pd_q;
        cdb_out.rob_id = rob_q;
        cdb_out.value  = result_q;
    end

    // Datapath and held payload
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            pd_q      <= '0;
            rob_q     <= '0;
        end else if (accept) begin
            pd_q      <= in_pd;
            rob_q     <= in_rob_id;
            is_rem_q  <= op_rem;
            neg_quo_q <= neg1 ^ neg2;
            neg_rem_q <= neg1;
            dsr_q     <= abs2;
            quo_q     <= abs1;
            rem_q     <= '0;
            counter_q <= special ? '0 : CNT_W'(XLEN);
            if (special) result_q <= special_val;
        end else if ((state_q == CALC) && !flush) begin
            rem_q     <= step_rem;
            quo_q     <= step_quo;
            counter_q <= counter_q - CNT_W'(1);
            if (counter_q == CNT_W'(1)) result_q <= final_val;
        end
    end

endmodule

// File: tb/tb_div_exec_unit.sv
// tb/tb_div_exec_unit.sv - directed self-checking bench for div_exec_unit
module tb_div_exec_unit;
    import div_exec_unit_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic [XLEN-1:0]      in_rs1_val;
    logic [XLEN-1:0]      in_rs2_val;
    logic [PREG_W-1:0]    in_pd;
    logic [ROB_IDX_W-1:0] in_rob_id;
    logic                 cdb_req;
    logic                 cdb_grant;
    cdb_t                 cdb_out;
    logic                 busy;

    int checks = 0;
    int passed = 0;

    div_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .in_pd      (in_pd),
        .in_rob_id  (in_rob_id),
        .cdb_req    (cdb_req),
        .cdb_grant  (cdb_grant),
        .cdb_out    (cdb_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] pd, input logic [4:0] rob);
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1_val = a;
        in_rs2_val = b;
        in_pd      = pd;
        in_rob_id  = rob;
    endtask

    // Waits for cdb_req after an accept edge; lat counts the accept cycle as 0.
    task automatic wait_req(output int lat);
        lat = 1;
        while (!cdb_req && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue one op from IDLE, wait for its request, grant it for one cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] pd, input logic [4:0] rob,
                          output logic [31:0] val, output int lat,
                          output logic [5:0] p, output logic [4:0] r, output logic v);
        drive_op(op, a, b, pd, rob);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_req(lat);
        val = cdb_out.value;
        p   = cdb_out.preg;
        r   = cdb_out.rob_id;
        cdb_grant = 1'b1;
        #1;
        v = cdb_out.valid;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; cdb_grant = 1'b0;
        in_op = 2'b00; in_rs1_val = '0; in_rs2_val = '0; in_pd = '0; in_rob_id = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (cdb_req !== 1'b0) $display("FAIL reset_cdb_req got %b want 0", cdb_req); else passed++;
        checks++; if (cdb_out.valid !== 1'b0) $display("FAIL reset_valid got %b want 0", cdb_out.valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_unsigned();
        logic [31:0] val; int lat; logic [5:0] p; logic [4:0] r; logic v;
        run_op(2'b01, 32'd100, 32'd7, 6'd17, 5'd9, val, lat, p, r, v);
        checks++; if (lat !== 33) $display("FAIL divu_latency got %0d want 33", lat); else passed++;
        checks++; if (val !== 32'd14) $display("FAIL divu_value got %h want 0000000e", val); else passed++;
        checks++; if (p !== 6'd17) $display("FAIL divu_preg got %0d want 17", p); else passed++;
        checks++; if (r !== 5'd9) $display("FAIL divu_rob got %0d want 9", r); else passed++;
        checks++; if (v !== 1'b1) $display("FAIL divu_valid got %b want 1", v); else passed++;
        run_op(2'b11, 32'd100, 32'd7, 6'd0, 5'd31, val, lat, p, r, v);
        checks++; if (val !== 32'd2) $display("FAIL remu_value got %h want 00000002", val); else passed++;
        checks++; if (p !== 6'd0) $display("FAIL remu_preg0 got %0d want 0", p); else passed++;
        checks++; if (v !== 1'b1) $display("FAIL remu_preg0_valid got %b want 1", v); else passed++;
    endtask

    task automatic test_signed();
        logic [31:0] val; int lat; logic [5:0] p; logic [4:0] r; logic v;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 6'd1, 5'd1, val, lat, p, r, v);
        checks++; if (val !== 32'hFFFF_FFFD) $display("FAIL div_neg_pos got %h want fffffffd", val); else passed++;
        checks++; if (lat !== 33) $display("FAIL div_latency got %0d want 33", lat); else passed++;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 6'd2, 5'd2, val, lat, p, r, v);
        checks++; if (val !== 32'hFFFF_FFFF) $display("FAIL rem_neg_pos got %h want ffffffff", val); else passed++;
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 6'd3, 5'd3, val, lat, p, r, v);
        checks++; if (val !== 32'd1) $display("FAIL rem_pos_neg got %h want 00000001", val); else passed++;
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 6'd4, 5'd4, val, lat, p, r, v);
        checks++; if (val !== 32'hFFFF_FFFD) $display("FAIL div_pos_neg got %h want fffffffd", val); else passed++;
        run_op(2'b00, 32'h8000_0000, 32'd2, 6'd5, 5'd5, val, lat, p, r, v);
        checks++; if (val !== 32'hC000_0000) $display("FAIL div_intmin_2 got %h want c0000000", val); else passed++;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 5'd6, val, lat, p, r, v);
        checks++; if (val !== 32'd1) $display("FAIL divu_max_max got %h want 00000001", val); else passed++;
    endtask

    task automatic test_special();
        logic [31:0] val; int lat; logic [5:0] p; logic [4:0] r; logic v;
        run_op(2'b01, 32'd55, 32'd0, 6'd7, 5'd7, val, lat, p, r, v);
        checks++; if (val !== 32'hFFFF_FFFF) $display("FAIL divu_by0 got %h want ffffffff", val); else passed++;
        checks++; if (lat !== 1) $display("FAIL divu_by0_latency got %0d want 1", lat); else passed++;
        run_op(2'b10, 32'h0000_1234, 32'd0, 6'd8, 5'd8, val, lat, p, r, v);
        checks++; if (val !== 32'h0000_1234) $display("FAIL rem_by0 got %h want 00001234", val); else passed++;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd9, 5'd10, val, lat, p, r, v);
        checks++; if (val !== 32'h8000_0000) $display("FAIL div_ovf got %h want 80000000", val); else passed++;
        checks++; if (lat !== 1) $display("FAIL div_ovf_latency got %0d want 1", lat); else passed++;
        checks++; if (r !== 5'd10) $display("FAIL div_ovf_rob got %0d want 10", r); else passed++;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 5'd11, val, lat, p, r, v);
        checks++; if (val !== 32'd0) $display("FAIL rem_ovf got %h want 00000000", val); else passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        drive_op(2'b01, 32'd1000, 32'd10, 6'd20, 5'd12);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_req(lat);
        checks++; if (lat !== 33) $display("FAIL hold_latency got %0d want 33", lat); else passed++;
        for (int i = 0; i < 10; i++) begin
            checks++; if (cdb_req !== 1'b1) $display("FAIL hold_req cyc %0d got %b want 1", i, cdb_req); else passed++;
            checks++; if (cdb_out.value !== 32'd100) $display("FAIL hold_value cyc %0d got %h want 00000064", i, cdb_out.value); else passed++;
            checks++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready cyc %0d got %b want 0", i, in_ready); else passed++;
            @(posedge clk); #1;
        end
        cdb_grant = 1'b1;
        drive_op(2'b01, 32'd50, 32'd5, 6'd21, 5'd13);
        #1;
        checks++; if (cdb_out.valid !== 1'b1) $display("FAIL grant_valid got %b want 1", cdb_out.valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL grant_in_ready got %b want 1", in_ready); else passed++;
        checks++; if (cdb_out.preg !== 6'd20) $display("FAIL grant_preg got %0d want 20", cdb_out.preg); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (cdb_out.valid !== 1'b0) $display("FAIL valid_one_cycle got %b want 0", cdb_out.valid); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", busy); else passed++;
        cdb_grant = 1'b0;
        wait_req(lat);
        checks++; if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else passed++;
        checks++; if (cdb_out.value !== 32'd10) $display("FAIL b2b_value got %h want 0000000a", cdb_out.value); else passed++;
        checks++; if (cdb_out.preg !== 6'd21) $display("FAIL b2b_preg got %0d want 21", cdb_out.preg); else passed++;
        cdb_grant = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
    endtask

    task automatic test_flush_reset();
        logic [31:0] val; int lat; logic [5:0] p; logic [4:0] r; logic v;
        bit saw;
        for (int k = 0; k < 2; k++) begin
            drive_op(2'b01, 32'd100, 32'd7, 6'd30, 5'd20);
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            checks++; if (busy !== 1'b1) $display("FAIL kill%0d_busy_before got %b want 1", k, busy); else passed++;
            if (k == 0) flush = 1'b1; else rst = 1'b1;
            #1;
            if (k == 0) begin
                checks++; if (cdb_req !== 1'b0) $display("FAIL flush_cycle_req got %b want 0", cdb_req); else passed++;
            end
            @(posedge clk); #1;
            flush = 1'b0; rst = 1'b0;
            checks++; if (busy !== 1'b0) $display("FAIL kill%0d_idle got %b want 0", k, busy); else passed++;
            saw = 1'b0;
            cdb_grant = 1'b1;
            for (int i = 0; i < 40; i++) begin
                if (cdb_req || cdb_out.valid) saw = 1'b1;
                @(posedge clk); #1;
            end
            cdb_grant = 1'b0;
            checks++; if (saw !== 1'b0) $display("FAIL kill%0d_no_broadcast got %b want 0", k, saw); else passed++;
            run_op(2'b01, 32'd9, 32'd3, 6'd31, 5'd21, val, lat, p, r, v);
            checks++; if (val !== 32'd3) $display("FAIL kill%0d_next_value got %h want 00000003", k, val); else passed++;
            checks++; if (lat !== 33) $display("FAIL kill%0d_next_latency got %0d want 33", k, lat); else passed++;
        end
        // A flush in IDLE blocks a simultaneous issue.
        drive_op(2'b01, 32'd9, 32'd0, 6'd1, 5'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL flush_blocks_accept got %b want 0", busy); else passed++;
    endtask

    task automatic test_valid_during_calc();
        int lat;
        drive_op(2'b01, 32'd100, 32'd7, 6'd1, 5'd1);
        @(posedge clk); #1;
        drive_op(2'b11, 32'd77, 32'd5, 6'd2, 5'd2);
        wait_req(lat);
        checks++; if (lat !== 33) $display("FAIL calc_hold_latency got %0d want 33", lat); else passed++;
        checks++; if (cdb_out.value !== 32'd14) $display("FAIL calc_hold_value got %h want 0000000e", cdb_out.value); else passed++;
        checks++; if (cdb_out.preg !== 6'd1) $display("FAIL calc_hold_preg got %0d want 1", cdb_out.preg); else passed++;
        cdb_grant = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
        in_valid = 1'b0;
        wait_req(lat);
        checks++; if (lat !== 33) $display("FAIL pending_latency got %0d want 33", lat); else passed++;
        checks++; if (cdb_out.value !== 32'd2) $display("FAIL pending_value got %h want 00000002", cdb_out.value); else passed++;
        checks++; if (cdb_out.preg !== 6'd2) $display("FAIL pending_preg got %0d want 2", cdb_out.preg); else passed++;
        cdb_grant = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL final_idle got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush_reset();
        test_valid_during_calc();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
